memory_unit: RTL
================

MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 11: word-address width.
REQ-002 Parameter DATA_WIDTH, default 16: word width.
REQ-003 Parameter DEPTH, default 2048: number of words, equal to 2**ADDR_WIDTH.
REQ-004 Port clock  input  1: single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port memoryRead  input  1: CPU read request, sampled each rising edge.
REQ-007 Port memoryWrite  input  1: CPU write request, sampled each rising edge.
REQ-008 Port MAR  input  ADDR_WIDTH: CPU word address.
REQ-009 Port MBR  input  DATA_WIDTH: CPU write data.
REQ-010 Port memoryData  output  DATA_WIDTH: registered read data returned to the CPU.
REQ-011 Port loadValid  input  1: loader word valid.
REQ-012 Port loadData  input  DATA_WIDTH: loader word.
REQ-013 Port loadReady  output  1: unit accepts a loader word this cycle.
REQ-014 Port loadDone  input  1: loader finished, one-cycle pulse.
REQ-015 Port cpuEnable  output  1: CPU may run; high only in RUN.
REQ-016 Port loadCount  output  ADDR_WIDTH+1: number of words loaded.
REQ-017 Port loadError  output  1: sticky flag, loader overflow.

Function
REQ-018 The unit SHALL use a two-state FSM: LOAD (after reset) and RUN.
REQ-019 In LOAD, loadReady SHALL be high while loadCount < DEPTH.
REQ-020 In LOAD, a word SHALL be accepted when loadValid and loadReady are both high; it is written to address loadCount[ADDR_WIDTH-1:0] and loadCount increments by 1.
REQ-021 In LOAD with loadCount == DEPTH, loadValid high SHALL set loadError; the word is dropped and there is no address wrap.
REQ-022 In LOAD, loadDone high SHALL move the FSM to RUN at that edge; if a valid word is accepted on the same edge, it is still written.
REQ-023 The RUN state SHALL be terminal until reset; loadReady is 0 and loader inputs are ignored in RUN.
REQ-024 In LOAD, memoryRead and memoryWrite SHALL be ignored and memoryData SHALL hold 0.
REQ-025 In RUN, memoryWrite sampled high SHALL write MBR to mem[MAR] at that edge.
REQ-026 In RUN, memoryRead sampled high SHALL load mem[MAR] into memoryData at that edge (one-cycle latency); the value is valid the following cycle.
REQ-027 memoryData SHALL hold its last value until the next sampled read or write.
REQ-028 In RUN, memoryRead and memoryWrite high together SHALL write MBR to mem[MAR] and set memoryData = MBR (write-first).
REQ-029 A write alone SHALL leave memoryData unchanged.
REQ-030 A read issued on the cycle after a write to the same address SHALL return the newly written data.
REQ-031 cpuEnable SHALL be a registered output, asserted on the first cycle in RUN.

Reset
REQ-032 Reset SHALL asynchronously force: state = LOAD, loadCount = 0, loadError = 0, memoryData = 0, cpuEnable = 0, loadReady = 1.
REQ-033 Reset SHALL NOT clear memory contents.
REQ-034 Reset asserted mid-load SHALL drop any in-progress accept; after release, loading restarts at address 0.

Structure
REQ-035 The parameter defaults and the FSM state encoding (LOAD = 0, RUN = 1) SHALL live in shared package cpu_mem_pkg.
REQ-036 The storage array SHALL be a single sub-module, ram_sp (single-port, synchronous write, synchronous write-first read).
REQ-037 memory_unit SHALL contain the FSM, the load counter, and the port muxing.

Verification
REQ-038 Scenario, load path: load words 0x1005, 0x3006, 0xBEEF, then pulse loadDone -> loadCount = 3, cpuEnable = 1 on the next cycle, and reads of addresses 0, 1, 2 return those words one cycle after each request.
REQ-039 Scenario, write then read: in RUN, write 0x8001 to address 0x7FF, then read 0x7FF on the next cycle -> memoryData = 0x8001 one cycle later; memoryData is unchanged during the write cycle.
REQ-040 Scenario, simultaneous request: memoryRead and memoryWrite high together with MAR = 5, MBR = 0x00AA -> memoryData = 0x00AA and a later read of address 5 returns 0x00AA.
REQ-041 Scenario, overflow: load 2048 words, then assert loadValid once more -> loadReady = 0, loadError = 1, and mem[0] still holds the first loaded word.
REQ-042 Scenario, reset mid-load: assert reset after 10 words, then load 1 word -> that word is at address 0, loadCount = 1, and addresses 1-9 keep their pre-reset data.
REQ-043 Scenario, LOAD isolation: drive memoryRead and memoryWrite in LOAD -> memoryData stays 0 and the memory is not modified.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory unit: default geometry and the
// load/run state encoding used by the controller.
package cpu_mem_pkg;

  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int DEPTH_DEF      = 2048;

  // LOAD fills memory from the loader, RUN hands the memory to the CPU.
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/ram_sp.sv
// Single-port word RAM with synchronous write and a registered, write-first
// read. The read register only updates when a read is requested, so it
// naturally holds the last value returned.
module ram_sp #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock_i,
  input  logic                  writeEnable_i,
  input  logic                  readEnable_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] writeData_i,
  output logic [DATA_WIDTH-1:0] readData_o
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] readData_q;

  // Storage update and write-first read capture; no reset so contents survive it.
  always_ff @(posedge clock_i) begin
    if (writeEnable_i) begin
      mem[addr_i] <= writeData_i;
    end
    if (readEnable_i) begin
      readData_q <= writeEnable_i ? writeData_i : mem[addr_i];
    end
  end

  assign readData_o = readData_q;

endmodule

// File: rtl/memory_unit.sv
// Memory unit shared between a boot loader and the CPU. After reset the unit
// accepts a stream of loader words into consecutive addresses; once the loader
// signals completion the CPU gets exclusive read/write access until reset.
module memory_unit
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memoryRead,
  input  logic                  memoryWrite,
  input  logic [ADDR_WIDTH-1:0] MAR,
  input  logic [DATA_WIDTH-1:0] MBR,
  output logic [DATA_WIDTH-1:0] memoryData,
  input  logic                  loadValid,
  input  logic [DATA_WIDTH-1:0] loadData,
  output logic                  loadReady,
  input  logic                  loadDone,
  output logic                  cpuEnable,
  output logic [ADDR_WIDTH:0]   loadCount,
  output logic                  loadError
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  mem_state_e            state_q, state_d;
  logic [ADDR_WIDTH:0]   loadCount_q, loadCount_d;
  logic                  loadError_q, loadError_d;
  logic                  cpuEnable_q;
  logic                  readSeen_q, readSeen_d;
  logic                  loadRoom;
  logic                  loadAccept;
  logic                  ramWe;
  logic                  ramRe;
  logic [ADDR_WIDTH-1:0] ramAddr;
  logic [DATA_WIDTH-1:0] ramWdata;
  logic [DATA_WIDTH-1:0] ramRdata;

  // Next-state, load bookkeeping and RAM port steering between loader and CPU.
  always_comb begin
    state_d     = state_q;
    loadCount_d = loadCount_q;
    loadError_d = loadError_q;
    readSeen_d  = readSeen_q;
    loadRoom    = 1'b0;
    loadReady   = 1'b0;
    loadAccept  = 1'b0;
    ramWe       = 1'b0;
    ramRe       = 1'b0;
    ramAddr     = MAR;
    ramWdata    = MBR;
    case (state_q)
      LOAD: begin
        loadRoom   = (loadCount_q < DEPTH_CNT);
        loadReady  = loadRoom;
        loadAccept = loadValid && loadRoom && !reset;
        ramAddr    = loadCount_q[ADDR_WIDTH-1:0];
        ramWdata   = loadData;
        ramWe      = loadAccept;
        if (loadAccept) begin
          loadCount_d = loadCount_q + 1'b1;
        end
        if (loadValid && !loadRoom) begin
          loadError_d = 1'b1;
        end
        if (loadDone) begin
          state_d = RUN;
        end
      end
      RUN: begin
        ramWe = memoryWrite;
        ramRe = memoryRead;
        if (memoryRead) begin
          readSeen_d = 1'b1;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Controller registers; reset returns to LOAD with an empty load count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      loadCount_q <= '0;
      loadError_q <= 1'b0;
      cpuEnable_q <= 1'b0;
      readSeen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      loadCount_q <= loadCount_d;
      loadError_q <= loadError_d;
      cpuEnable_q <= (state_d == RUN);
      readSeen_q  <= readSeen_d;
    end
  end

  ram_sp #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) uRam (
    .clock_i      (clock),
    .writeEnable_i(ramWe),
    .readEnable_i (ramRe),
    .addr_i       (ramAddr),
    .writeData_i  (ramWdata),
    .readData_o   (ramRdata)
  );

  // The RAM read register has no reset, so report zero until the CPU reads.
  assign memoryData = readSeen_q ? ramRdata : '0;
  assign cpuEnable  = cpuEnable_q;
  assign loadCount  = loadCount_q;
  assign loadError  = loadError_q;

endmodule
